// File: rtl/mips_pkg.sv
// Shared MIPS core definitions.
// FSM encoding and instruction constants.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          WORD_SHIFT = 2;

endpackage

// File: rtl/instr_ram.sv
// Instruction RAM: one write port and one
// synchronous read port with read enable.
module instr_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64,
  parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Word write from the load port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; rdata holds while re is low
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory with registered
// fetch port, stall hold and fault flags.
module instr_fetch_mem
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_en,
  input  logic                  run_en,
  input  logic                  load_we,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [15:0]           load_count,
  output logic                  load_err,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_stall,
  output logic                  fetch_ready,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  output logic                  fault_misal,
  output logic                  fault_range,
  output logic [1:0]            mode
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A =
    ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [DATA_WIDTH-1:0] NOP_W =
    DATA_WIDTH'(NOP_INSTR);

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] l_idx, f_idx;
  logic                  l_ok, l_wr, l_drop;
  logic                  f_misal, f_range;
  logic                  accept, enter_load;
  logic                  rd_en, nop_sel;
  logic [DATA_WIDTH-1:0] rdata;

  assign l_idx   = load_addr >> WORD_SHIFT;
  assign f_idx   = fetch_addr >> WORD_SHIFT;
  assign l_ok    = (load_addr[1:0] == 2'b00)
                 & (l_idx < DEPTH_A);
  assign l_wr    = (state == LOAD) & load_we & l_ok;
  assign l_drop  = (state == LOAD) & load_we & !l_ok;
  assign f_misal = (fetch_addr[1:0] != 2'b00);
  assign f_range = (f_idx >= DEPTH_A);

  assign fetch_ready = (state == RUN) & !fetch_stall;
  assign accept      = fetch_req & fetch_ready;
  assign rd_en       = accept & !f_misal & !f_range;
  assign enter_load  = (state != LOAD)
                     & (state_nx == LOAD);
  assign instr       = nop_sel ? NOP_W : rdata;
  assign mode        = state;

  instr_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (l_wr),
    .waddr(l_idx[IDX_W-1:0]),
    .wdata(load_data),
    .re   (rd_en),
    .raddr(f_idx[IDX_W-1:0]),
    .rdata(rdata)
  );

  // Mode state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-mode decode, program load has priority
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (prog_en)     state_nx = LOAD;
        else if (run_en) state_nx = RUN;
      end
      LOAD: if (!prog_en) state_nx = IDLE;
      RUN:  if (prog_en)  state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  // Load word counter and sticky drop flag
  always_ff @(posedge clk) begin
    if (rst || enter_load) begin
      load_count <= '0;
      load_err   <= 1'b0;
    end else begin
      if (l_wr && load_count != 16'hFFFF)
        load_count <= load_count + 16'd1;
      if (l_drop)
        load_err <= 1'b1;
    end
  end

  // Fetch result registers with stall hold
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_valid <= 1'b0;
      instr_addr  <= '0;
      fault_misal <= 1'b0;
      fault_range <= 1'b0;
      nop_sel     <= 1'b1;
    end else if (enter_load || state != RUN) begin
      instr_valid <= 1'b0;
    end else if (!fetch_stall) begin
      instr_valid <= fetch_req;
      if (fetch_req) begin
        instr_addr  <= fetch_addr;
        fault_misal <= f_misal;
        fault_range <= f_range;
        nop_sel     <= f_misal | f_range;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem.
// Inputs change 1ns after posedge, checks follow.
module tb_instr_fetch_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_en, run_en, load_we;
  logic [31:0] load_addr, load_data;
  logic [15:0] load_count;
  logic        load_err;
  logic        fetch_req, fetch_stall, fetch_ready;
  logic [31:0] fetch_addr;
  logic        instr_valid;
  logic [31:0] instr, instr_addr;
  logic        fault_misal, fault_range;
  logic [1:0]  mode;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_fetch_mem dut (
    .clk        (clk),
    .rst        (rst),
    .prog_en    (prog_en),
    .run_en     (run_en),
    .load_we    (load_we),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_count (load_count),
    .load_err   (load_err),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_stall(fetch_stall),
    .fetch_ready(fetch_ready),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_addr (instr_addr),
    .fault_misal(fault_misal),
    .fault_range(fault_range),
    .mode       (mode)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_we   = 1'b0;
  endtask

  task automatic res(input string tag,
                     input logic [31:0] d,
                     input logic [31:0] a,
                     input logic m,
                     input logic r);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_instr"}, instr, d);
    chk({tag, "_addr"}, instr_addr, a);
    chk({tag, "_misal"}, 32'(fault_misal), 32'(m));
    chk({tag, "_range"}, 32'(fault_range), 32'(r));
  endtask

  initial begin
    rst = 1'b1; prog_en = 0; run_en = 0;
    load_we = 0; load_addr = 0; load_data = 0;
    fetch_req = 0; fetch_addr = 0; fetch_stall = 0;
    step(); step();
    rst = 1'b0;
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_iaddr", instr_addr, 32'h0);
    chk("rst_cnt", 32'(load_count), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_misal", 32'(fault_misal), 32'd0);
    chk("rst_range", 32'(fault_range), 32'd0);
    chk("rst_ready", 32'(fetch_ready), 32'd0);

    // Load program
    prog_en = 1'b1;
    step();
    chk("load_mode", 32'(mode), 32'd1);
    wr(32'h0, 32'h0224_0020);
    wr(32'h14, 32'h8C0A_0020);
    chk("t1_cnt", 32'(load_count), 32'd2);
    chk("t1_err", 32'(load_err), 32'd0);
    wr(32'h4, 32'h1111_1111);
    wr(32'h8, 32'h2222_2222);
    chk("t1_cnt4", 32'(load_count), 32'd4);

    // Dropped writes
    wr(32'h102, 32'hDEAD_BEEF);
    chk("t2_err1", 32'(load_err), 32'd1);
    wr(32'h100, 32'hDEAD_BEEF);
    chk("t2_err", 32'(load_err), 32'd1);
    chk("t2_cnt", 32'(load_count), 32'd4);

    prog_en = 1'b0;
    step();
    chk("idle_mode", 32'(mode), 32'd0);
    run_en = 1'b1;
    step();
    run_en = 1'b0;
    chk("run_mode", 32'(mode), 32'd2);
    chk("run_ready", 32'(fetch_ready), 32'd1);

    // Single fetch
    fetch_req = 1'b1; fetch_addr = 32'h0;
    step();
    fetch_req = 1'b0;
    res("t1_f0", 32'h0224_0020, 32'h0, 0, 0);
    step();
    chk("idle_valid", 32'(instr_valid), 32'd0);
    chk("idle_hold", instr, 32'h0224_0020);

    // Back-to-back with a stall
    fetch_req = 1'b1; fetch_addr = 32'h0;
    step();
    res("t3_a0", 32'h0224_0020, 32'h0, 0, 0);
    fetch_addr = 32'h4;
    step();
    res("t3_a4", 32'h1111_1111, 32'h4, 0, 0);
    fetch_stall = 1'b1; fetch_addr = 32'h8;
    #1;
    chk("t3_rdy", 32'(fetch_ready), 32'd0);
    step();
    res("t3_hold", 32'h1111_1111, 32'h4, 0, 0);
    fetch_stall = 1'b0;
    step();
    res("t3_a8", 32'h2222_2222, 32'h8, 0, 0);

    // Faults
    fetch_addr = 32'h3;
    step();
    res("t4_mis", 32'h0, 32'h3, 1, 0);
    fetch_addr = 32'h200;
    step();
    res("t4_rng", 32'h0, 32'h200, 0, 1);
    fetch_addr = 32'h14;
    step();
    res("t4_ok", 32'h8C0A_0020, 32'h14, 0, 0);
    fetch_addr = 32'h201;
    step();
    res("t4_both", 32'h0, 32'h201, 1, 1);

    // Reprogram while fetching
    fetch_addr = 32'h0; prog_en = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("t5_mode", 32'(mode), 32'd1);
    chk("t5_valid", 32'(instr_valid), 32'd0);
    chk("t5_ready", 32'(fetch_ready), 32'd0);
    chk("t5_cnt", 32'(load_count), 32'd0);
    chk("t5_err", 32'(load_err), 32'd0);

    // Reset during load
    wr(32'h8, 32'h3333_3333);
    wr(32'hC, 32'h4444_4444);
    wr(32'h10, 32'h5555_5555);
    chk("t6_cnt3", 32'(load_count), 32'd3);
    rst = 1'b1; prog_en = 1'b0;
    step();
    rst = 1'b0;
    chk("t6_mode", 32'(mode), 32'd0);
    chk("t6_cnt", 32'(load_count), 32'd0);
    chk("t6_valid", 32'(instr_valid), 32'd0);
    run_en = 1'b1;
    step();
    run_en = 1'b0;
    chk("t6_run", 32'(mode), 32'd2);
    fetch_req = 1'b1; fetch_addr = 32'h8;
    step();
    res("t6_f8", 32'h3333_3333, 32'h8, 0, 0);
    fetch_addr = 32'h0;
    step();
    fetch_req = 1'b0;
    res("t6_f0", 32'h0224_0020, 32'h0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
